// File: rtl/cache_axi_arbiter.sv
// Two-port AXI3 arbiter: I-cache (port 0) and D-cache (port 1) miss handlers
// share one master port, one whole transaction at a time, round-robin on contention.
module cache_axi_arbiter #(
  parameter logic RST_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  // port 0 (I-cache)
  input  logic [3:0]  s0_arid,
  input  logic [31:0] s0_araddr,
  input  logic [7:0]  s0_arlen,
  input  logic [2:0]  s0_arsize,
  input  logic [1:0]  s0_arburst,
  input  logic [1:0]  s0_arlock,
  input  logic [3:0]  s0_arcache,
  input  logic [2:0]  s0_arprot,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [3:0]  s0_rid,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rlast,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  input  logic [3:0]  s0_awid,
  input  logic [31:0] s0_awaddr,
  input  logic [7:0]  s0_awlen,
  input  logic [2:0]  s0_awsize,
  input  logic [1:0]  s0_awburst,
  input  logic [1:0]  s0_awlock,
  input  logic [3:0]  s0_awcache,
  input  logic [2:0]  s0_awprot,
  input  logic        s0_awvalid,
  output logic        s0_awready,
  input  logic [3:0]  s0_wid,
  input  logic [31:0] s0_wdata,
  input  logic [3:0]  s0_wstrb,
  input  logic        s0_wlast,
  input  logic        s0_wvalid,
  output logic        s0_wready,
  output logic [3:0]  s0_bid,
  output logic [1:0]  s0_bresp,
  output logic        s0_bvalid,
  input  logic        s0_bready,
  // port 1 (D-cache)
  input  logic [3:0]  s1_arid,
  input  logic [31:0] s1_araddr,
  input  logic [7:0]  s1_arlen,
  input  logic [2:0]  s1_arsize,
  input  logic [1:0]  s1_arburst,
  input  logic [1:0]  s1_arlock,
  input  logic [3:0]  s1_arcache,
  input  logic [2:0]  s1_arprot,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [3:0]  s1_rid,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rlast,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  input  logic [3:0]  s1_awid,
  input  logic [31:0] s1_awaddr,
  input  logic [7:0]  s1_awlen,
  input  logic [2:0]  s1_awsize,
  input  logic [1:0]  s1_awburst,
  input  logic [1:0]  s1_awlock,
  input  logic [3:0]  s1_awcache,
  input  logic [2:0]  s1_awprot,
  input  logic        s1_awvalid,
  output logic        s1_awready,
  input  logic [3:0]  s1_wid,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_wlast,
  input  logic        s1_wvalid,
  output logic        s1_wready,
  output logic [3:0]  s1_bid,
  output logic [1:0]  s1_bresp,
  output logic        s1_bvalid,
  input  logic        s1_bready,
  // master port to the bus
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [1:0]  m_arlock,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic [1:0]  m_awlock,
  output logic [3:0]  m_awcache,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [3:0]  m_wid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  // debug view of the arbiter state
  output logic [1:0]  o_state,
  output logic        o_owner,
  output logic        o_last_owner
);

  // Handshakes: a beat transfers on the rising edge where valid && ready are both 1;
  // valid never waits on ready, and every valid/ready seen by a port is gated by ownership.
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  state_t     r_state;
  logic       r_owner;
  logic       r_last_owner;
  logic       r_ar_done;
  logic       r_aw_done;
  logic       r_w_done;
  logic [3:0] r_arid;
  logic [3:0] r_awid;

  logic w_rd, w_wr, w_req0, w_req1, w_win, w_win_aw;
  logic w_own_arvalid, w_own_awvalid, w_own_wvalid, w_own_rready, w_own_bready;
  logic w_ar_ok, w_aw_ok, w_w_ok;

  assign w_rd   = (r_state == RD);
  assign w_wr   = (r_state == WR);
  assign w_req0 = s0_arvalid | s0_awvalid;
  assign w_req1 = s1_arvalid | s1_awvalid;
  assign w_win    = (w_req0 && w_req1) ? ~r_last_owner : w_req1;
  assign w_win_aw = w_win ? s1_awvalid : s0_awvalid;

  assign w_own_arvalid = r_owner ? s1_arvalid : s0_arvalid;
  assign w_own_awvalid = r_owner ? s1_awvalid : s0_awvalid;
  assign w_own_wvalid  = r_owner ? s1_wvalid  : s0_wvalid;
  assign w_own_rready  = r_owner ? s1_rready  : s0_rready;
  assign w_own_bready  = r_owner ? s1_bready  : s0_bready;

  // Master read address: the ID carries the port number so the bus sees distinct masters.
  assign m_arid    = {3'b000, r_owner};
  assign m_araddr  = r_owner ? s1_araddr  : s0_araddr;
  assign m_arlen   = r_owner ? s1_arlen   : s0_arlen;
  assign m_arsize  = r_owner ? s1_arsize  : s0_arsize;
  assign m_arburst = r_owner ? s1_arburst : s0_arburst;
  assign m_arlock  = r_owner ? s1_arlock  : s0_arlock;
  assign m_arcache = r_owner ? s1_arcache : s0_arcache;
  assign m_arprot  = r_owner ? s1_arprot  : s0_arprot;
  assign m_arvalid = w_rd && w_own_arvalid && !r_ar_done;
  assign w_ar_ok   = w_rd && m_arready && !r_ar_done;
  assign s0_arready = w_ar_ok && !r_owner;
  assign s1_arready = w_ar_ok && r_owner;

  assign m_rready  = w_rd && w_own_rready;
  assign s0_rid    = r_arid;
  assign s1_rid    = r_arid;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rlast  = m_rlast;
  assign s1_rlast  = m_rlast;
  assign s0_rvalid = w_rd && m_rvalid && !r_owner;
  assign s1_rvalid = w_rd && m_rvalid && r_owner;

  assign m_awid    = {3'b000, r_owner};
  assign m_awaddr  = r_owner ? s1_awaddr  : s0_awaddr;
  assign m_awlen   = r_owner ? s1_awlen   : s0_awlen;
  assign m_awsize  = r_owner ? s1_awsize  : s0_awsize;
  assign m_awburst = r_owner ? s1_awburst : s0_awburst;
  assign m_awlock  = r_owner ? s1_awlock  : s0_awlock;
  assign m_awcache = r_owner ? s1_awcache : s0_awcache;
  assign m_awprot  = r_owner ? s1_awprot  : s0_awprot;
  assign m_awvalid = w_wr && w_own_awvalid && !r_aw_done;
  assign w_aw_ok   = w_wr && m_awready && !r_aw_done;
  assign s0_awready = w_aw_ok && !r_owner;
  assign s1_awready = w_aw_ok && r_owner;

  // WID follows the rewritten AWID so the interconnect can pair W beats with AW.
  assign m_wid     = {3'b000, r_owner};
  assign m_wdata   = r_owner ? s1_wdata : s0_wdata;
  assign m_wstrb   = r_owner ? s1_wstrb : s0_wstrb;
  assign m_wlast   = r_owner ? s1_wlast : s0_wlast;
  assign m_wvalid  = w_wr && w_own_wvalid && !r_w_done;
  assign w_w_ok    = w_wr && m_wready && !r_w_done;
  assign s0_wready = w_w_ok && !r_owner;
  assign s1_wready = w_w_ok && r_owner;

  assign m_bready  = w_wr && w_own_bready;
  assign s0_bid    = r_awid;
  assign s1_bid    = r_awid;
  assign s0_bresp  = m_bresp;
  assign s1_bresp  = m_bresp;
  assign s0_bvalid = w_wr && m_bvalid && !r_owner;
  assign s1_bvalid = w_wr && m_bvalid && r_owner;

  assign o_state      = r_state;
  assign o_owner      = r_owner;
  assign o_last_owner = r_last_owner;

  // Bus IDs are implied by ownership and the port WIDs are replaced, so these are sinks.
  logic w_unused;
  assign w_unused = &{1'b0, m_rid, m_bid, s0_wid, s1_wid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= RST_PRIO;
      r_last_owner <= ~RST_PRIO;
      r_ar_done    <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_arid       <= 4'd0;
      r_awid       <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req0 || w_req1) begin
            r_owner      <= w_win;
            r_last_owner <= w_win;
            r_arid       <= w_win ? s1_arid : s0_arid;
            r_awid       <= w_win ? s1_awid : s0_awid;
            r_state      <= w_win_aw ? WR : RD;
          end
        end
        RD: begin
          if (m_arvalid && m_arready) r_ar_done <= 1'b1;
          if (m_rvalid && m_rready && m_rlast) begin
            r_state   <= IDLE;
            r_ar_done <= 1'b0;
          end
        end
        WR: begin
          if (m_awvalid && m_awready) r_aw_done <= 1'b1;
          if (m_wvalid && m_wready && m_wlast) r_w_done <= 1'b1;
          if (m_bvalid && m_bready) begin
            r_state   <= IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: a per-cycle vector table for arbitration and
// handshake gating, plus sequences for bursts, SLVERR forwarding and mid-burst reset.
module tb_cache_axi_arbiter;

  logic clk, rst;
  logic [3:0] s0_arid, s1_arid, s0_awid, s1_awid, s0_wid, s1_wid;
  logic [31:0] s0_araddr, s1_araddr, s0_awaddr, s1_awaddr, s0_wdata, s1_wdata;
  logic [7:0] s0_arlen, s1_arlen, s0_awlen, s1_awlen;
  logic [2:0] s0_arsize, s1_arsize, s0_awsize, s1_awsize, s0_arprot, s1_arprot, s0_awprot, s1_awprot;
  logic [1:0] s0_arburst, s1_arburst, s0_awburst, s1_awburst, s0_arlock, s1_arlock, s0_awlock, s1_awlock;
  logic [3:0] s0_arcache, s1_arcache, s0_awcache, s1_awcache, s0_wstrb, s1_wstrb;
  logic s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid, s0_wlast, s1_wlast;
  logic s0_rready, s1_rready, s0_bready, s1_bready;
  logic s0_arready, s1_arready, s0_awready, s1_awready, s0_wready, s1_wready;
  logic [3:0] s0_rid, s1_rid, s0_bid, s1_bid;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0] s0_rresp, s1_rresp, s0_bresp, s1_bresp;
  logic s0_rlast, s1_rlast, s0_rvalid, s1_rvalid, s0_bvalid, s1_bvalid;
  logic [3:0] m_arid, m_awid, m_wid, m_rid, m_bid, m_arcache, m_awcache, m_wstrb;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [7:0] m_arlen, m_awlen;
  logic [2:0] m_arsize, m_awsize, m_arprot, m_awprot;
  logic [1:0] m_arburst, m_awburst, m_arlock, m_awlock, m_rresp, m_bresp;
  logic m_arvalid, m_arready, m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic m_rlast, m_rvalid, m_rready, m_bvalid, m_bready;
  logic [1:0] o_state;
  logic o_owner, o_last_owner;

  cache_axi_arbiter #(.RST_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .s0_arid(s0_arid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize),
    .s0_arburst(s0_arburst), .s0_arlock(s0_arlock), .s0_arcache(s0_arcache), .s0_arprot(s0_arprot),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_rid(s0_rid), .s0_rdata(s0_rdata),
    .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
    .s0_awburst(s0_awburst), .s0_awlock(s0_awlock), .s0_awcache(s0_awcache), .s0_awprot(s0_awprot),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_wid(s0_wid), .s0_wdata(s0_wdata),
    .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
    .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
    .s1_arid(s1_arid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize),
    .s1_arburst(s1_arburst), .s1_arlock(s1_arlock), .s1_arcache(s1_arcache), .s1_arprot(s1_arprot),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_rid(s1_rid), .s1_rdata(s1_rdata),
    .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
    .s1_awburst(s1_awburst), .s1_awlock(s1_awlock), .s1_awcache(s1_awcache), .s1_awprot(s1_awprot),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_wid(s1_wid), .s1_wdata(s1_wdata),
    .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
    .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wid(m_wid), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .o_state(o_state), .o_owner(o_owner), .o_last_owner(o_last_owner)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock, s0_arcache, s0_arprot} = '0;
    {s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock, s1_arcache, s1_arprot} = '0;
    {s0_awid, s0_awaddr, s0_awlen, s0_awsize, s0_awburst, s0_awlock, s0_awcache, s0_awprot} = '0;
    {s1_awid, s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock, s1_awcache, s1_awprot} = '0;
    {s0_wid, s0_wdata, s0_wstrb, s0_wlast, s1_wid, s1_wdata, s1_wstrb, s1_wlast} = '0;
    {s0_arvalid, s1_arvalid, s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid} = '0;
    {s0_rready, s1_rready, s0_bready, s1_bready} = 4'b1111;
    {m_arready, m_awready, m_wready, m_rvalid, m_rlast, m_bvalid} = '0;
    {m_rid, m_rdata, m_rresp, m_bid, m_bresp} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One table row = one clock cycle: inputs driven at negedge, outputs checked just after.
  typedef struct {
    logic [3:0] req;    // {s1_awvalid, s1_arvalid, s0_awvalid, s0_arvalid}
    logic [5:0] bus;    // {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid}
    logic [1:0] e_state;
    logic       e_owner;
    logic       e_arvalid;
    logic       e_awvalid;
    logic [3:0] e_arid;
    logic [1:0] e_s_arready; // {s1, s0}
    logic [1:0] e_s_rvalid;  // {s1, s0}
    logic       e_rready;
  } vec_t;

  function automatic vec_t mk(logic [3:0] req, logic [5:0] bus, logic [1:0] st, logic own,
                              logic arv, logic awv, logic [3:0] arid, logic [1:0] sar,
                              logic [1:0] srv, logic rr);
    vec_t v;
    v.req = req; v.bus = bus; v.e_state = st; v.e_owner = own; v.e_arvalid = arv;
    v.e_awvalid = awv; v.e_arid = arid; v.e_s_arready = sar; v.e_s_rvalid = srv; v.e_rready = rr;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    int beats, aw_hs;
    // Contended reads, sole requesters, write-before-read, late request at completion, alternation.
    vecs[0]  = mk(4'b0101, 6'b000000, 2'd0, 0, 0, 0, 4'd0, 2'b00, 2'b00, 0);
    vecs[1]  = mk(4'b0101, 6'b100000, 2'd1, 0, 1, 0, 4'd0, 2'b01, 2'b00, 1);
    vecs[2]  = mk(4'b0100, 6'b011000, 2'd1, 0, 0, 0, 4'd0, 2'b00, 2'b01, 1);
    vecs[3]  = mk(4'b0100, 6'b000000, 2'd0, 0, 0, 0, 4'd0, 2'b00, 2'b00, 0);
    vecs[4]  = mk(4'b0100, 6'b100000, 2'd1, 1, 1, 0, 4'd1, 2'b10, 2'b00, 1);
    vecs[5]  = mk(4'b0000, 6'b011000, 2'd1, 1, 0, 0, 4'd1, 2'b00, 2'b10, 1);
    vecs[6]  = mk(4'b0000, 6'b010001, 2'd0, 1, 0, 0, 4'd1, 2'b00, 2'b00, 0);
    vecs[7]  = mk(4'b1100, 6'b000000, 2'd0, 1, 0, 0, 4'd1, 2'b00, 2'b00, 0);
    vecs[8]  = mk(4'b1100, 6'b000100, 2'd2, 1, 0, 1, 4'd1, 2'b00, 2'b00, 0);
    vecs[9]  = mk(4'b0100, 6'b100001, 2'd2, 1, 0, 0, 4'd1, 2'b00, 2'b00, 0);
    vecs[10] = mk(4'b0100, 6'b000000, 2'd0, 1, 0, 0, 4'd1, 2'b00, 2'b00, 0);
    vecs[11] = mk(4'b0100, 6'b100000, 2'd1, 1, 1, 0, 4'd1, 2'b10, 2'b00, 1);
    vecs[12] = mk(4'b0000, 6'b010000, 2'd1, 1, 0, 0, 4'd1, 2'b00, 2'b10, 1);
    vecs[13] = mk(4'b0101, 6'b011000, 2'd1, 1, 0, 0, 4'd1, 2'b00, 2'b10, 1);
    vecs[14] = mk(4'b0101, 6'b000000, 2'd0, 1, 0, 0, 4'd1, 2'b00, 2'b00, 0);
    vecs[15] = mk(4'b0101, 6'b000000, 2'd1, 0, 1, 0, 4'd0, 2'b00, 2'b00, 1);
    vecs[16] = mk(4'b0101, 6'b100000, 2'd1, 0, 1, 0, 4'd0, 2'b01, 2'b00, 1);
    vecs[17] = mk(4'b0100, 6'b011000, 2'd1, 0, 0, 0, 4'd0, 2'b00, 2'b01, 1);
    vecs[18] = mk(4'b0100, 6'b000000, 2'd0, 0, 0, 0, 4'd0, 2'b00, 2'b00, 0);
    vecs[19] = mk(4'b0100, 6'b000000, 2'd1, 1, 1, 0, 4'd1, 2'b00, 2'b00, 1);

    rst = 1'b1;
    clear_inputs();
    do_reset();
    #1;
    chk("rst_state", o_state, 2'd0);
    chk("rst_owner", o_owner, 1'b0);
    chk("rst_last_owner", o_last_owner, 1'b1);
    chk("rst_master_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 5'd0);
    chk("rst_slave_outs", {s0_arready, s0_awready, s0_wready, s0_rvalid, s0_bvalid,
                           s1_arready, s1_awready, s1_wready, s1_rvalid, s1_bvalid}, 10'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      {s1_awvalid, s1_arvalid, s0_awvalid, s0_arvalid} = vecs[i].req;
      {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid} = vecs[i].bus;
      #1;
      chk($sformatf("v%0d_state", i), o_state, vecs[i].e_state);
      chk($sformatf("v%0d_owner", i), o_owner, vecs[i].e_owner);
      chk($sformatf("v%0d_m_arvalid", i), m_arvalid, vecs[i].e_arvalid);
      chk($sformatf("v%0d_m_awvalid", i), m_awvalid, vecs[i].e_awvalid);
      chk($sformatf("v%0d_m_arid", i), m_arid, vecs[i].e_arid);
      chk($sformatf("v%0d_s_arready", i), {s1_arready, s0_arready}, vecs[i].e_s_arready);
      chk($sformatf("v%0d_s_rvalid", i), {s1_rvalid, s0_rvalid}, vecs[i].e_s_rvalid);
      chk($sformatf("v%0d_m_rready", i), m_rready, vecs[i].e_rready);
    end

    // 16-beat writeback from s1 with stalls, SLVERR response, then a 16-beat fill.
    do_reset();
    s1_awvalid = 1'b1; s1_awid = 4'd3; s1_awlen = 8'd15; s1_awaddr = 32'h0000_1000;
    s1_wvalid = 1'b1; s1_wdata = 32'd0;
    #1;
    chk("wb_idle_no_valid", {m_awvalid, m_wvalid}, 2'b00);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'hA500 + k);
    beats = 0;
    aw_hs = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      s1_awvalid = (aw_hs == 0);
      m_awready  = 1'b1;
      m_wready   = (cyc % 3 != 2);
      s1_wvalid  = 1'b1;
      s1_wdata   = 32'hA500 + beats;
      s1_wlast   = (beats == 15);
      #1;
      if (m_awvalid && m_awready) begin
        aw_hs++;
        chk("wb_m_awid", m_awid, 4'd1);
        chk("wb_m_awlen", m_awlen, 8'd15);
      end
      if (m_wvalid && m_wready) begin
        beats++;
        if (exp_q.size() > 0) chk("wb_wdata", m_wdata, exp_q.pop_front());
        chk("wb_wlast", m_wlast, beats == 16);
      end
    end
    chk("wb_beat_count", beats, 16);
    chk("wb_aw_count", aw_hs, 1);
    chk("wb_queue_empty", exp_q.size(), 0);
    chk("wb_s1_wready_after_last", s1_wready, 1'b0);
    @(negedge clk);
    s1_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid = 1'b1; m_bresp = 2'b10; m_bid = 4'd1;
    #1;
    chk("wb_state_wr", o_state, 2'd2);
    chk("wb_s1_bvalid", s1_bvalid, 1'b1);
    chk("wb_s1_bresp_slverr", s1_bresp, 2'b10);
    chk("wb_s1_bid", s1_bid, 4'd3);
    chk("wb_s0_bvalid", s0_bvalid, 1'b0);
    chk("wb_m_bready", m_bready, 1'b1);
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00;
    s1_arvalid = 1'b1; s1_arid = 4'd9; s1_arlen = 8'd15;
    #1;
    chk("fill_idle_after_b", o_state, 2'd0);
    chk("fill_idle_no_arvalid", m_arvalid, 1'b0);
    @(negedge clk);
    m_arready = 1'b1;
    #1;
    chk("fill_state_rd", o_state, 2'd1);
    chk("fill_last_owner", o_last_owner, 1'b1);
    chk("fill_m_arvalid", m_arvalid, 1'b1);
    chk("fill_m_arid", m_arid, 4'd1);
    chk("fill_s1_arready", s1_arready, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s1_arvalid = 1'b0; m_arready = 1'b0;
      m_rvalid = 1'b1; m_rid = 4'd1; m_rdata = 32'hD000 + k; m_rlast = (k == 15);
      #1;
      chk("fill_s1_rvalid", s1_rvalid, 1'b1);
      chk("fill_s1_rid", s1_rid, 4'd9);
      chk("fill_s1_rdata", s1_rdata, 32'hD000 + k);
    end
    @(negedge clk);
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    chk("fill_done_idle", o_state, 2'd0);

    // Reset during beat 5 of an s0 read burst abandons it; a fresh request is then granted.
    do_reset();
    s0_arvalid = 1'b1; s0_arid = 4'd6;
    @(negedge clk);
    m_arready = 1'b1;
    #1;
    chk("rr_s0_arready", s0_arready, 1'b1);
    for (int b = 1; b <= 5; b++) begin
      @(negedge clk);
      s0_arvalid = 1'b0; m_arready = 1'b0;
      m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = b;
      if (b == 5) rst = 1'b1;
      #1;
      chk("rr_s0_rdata", s0_rdata, b);
      chk("rr_s0_rid", s0_rid, 4'd6);
    end
    @(negedge clk);
    #1;
    chk("rr_state_idle", o_state, 2'd0);
    chk("rr_master_zero", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 5'd0);
    chk("rr_slave_zero", {s0_arready, s0_awready, s0_wready, s0_rvalid, s0_bvalid,
                          s1_arready, s1_awready, s1_wready, s1_rvalid, s1_bvalid}, 10'd0);
    @(negedge clk);
    rst = 1'b0; m_rvalid = 1'b0; s0_arvalid = 1'b1;
    #1;
    chk("rr_fresh_idle", o_state, 2'd0);
    @(negedge clk);
    #1;
    chk("rr_fresh_state", o_state, 2'd1);
    chk("rr_fresh_owner", o_owner, 1'b0);
    chk("rr_fresh_arvalid", m_arvalid, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
